// File: rtl/rnd_cell_painter_pkg.sv
// Shared constants, word field layout and FSM encoding for the random cell painter.
package rnd_cell_painter_pkg;

    localparam int NUM_ENTRIES = 10;
    localparam int CELL_W_LOG2 = 3;
    localparam int CELL_H_LOG2 = 4;

    // Layout of one 13-bit random word
    localparam int WORD_W = 13;
    localparam int X_MSB  = 12;
    localparam int X_LSB  = 7;
    localparam int Y_MSB  = 6;
    localparam int Y_LSB  = 2;
    localparam int C_MSB  = 1;
    localparam int C_LSB  = 0;
    localparam int X_W    = X_MSB - X_LSB + 1;
    localparam int Y_W    = Y_MSB - Y_LSB + 1;
    localparam int C_W    = C_MSB - C_LSB + 1;

    // Column / row numbers derived from a 10-bit pixel coordinate
    localparam int COL_W  = 10 - CELL_W_LOG2;
    localparam int ROW_W  = 10 - CELL_H_LOG2;

    localparam int IDX_W  = 4;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2,
        READY = 2'd3
    } state_e;

endpackage

// File: rtl/rnd_cell_painter_decode.sv
// Splits one random word into its cell column, cell row and colour index.
module rnd_cell_decode
    import rnd_cell_painter_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [X_W-1:0]    x_cell_o,
    output logic [Y_W-1:0]    y_cell_o,
    output logic [C_W-1:0]    colour_o
);

    assign x_cell_o = word_i[X_MSB:X_LSB];
    assign y_cell_o = word_i[Y_MSB:Y_LSB];
    assign colour_o = word_i[C_MSB:C_LSB];

endmodule

// File: rtl/rnd_cell_painter.sv
// Paints up to ten 8x16 cells whose positions and colours come from random words.
// A frame snapshot is taken once per frame; each line's hit mask is built during
// horizontal blanking and swapped in at the start of the line.
// Optional: define RND_CELL_PAINTER_OUTLINE_EN to draw 1-px cell outlines instead of fills.
module rnd_cell_painter
    import rnd_cell_painter_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_ACTIVE = 480
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] rnd_0,
    input  logic [WORD_W-1:0] rnd_1,
    input  logic [WORD_W-1:0] rnd_2,
    input  logic [WORD_W-1:0] rnd_3,
    input  logic [WORD_W-1:0] rnd_4,
    input  logic [WORD_W-1:0] rnd_5,
    input  logic [WORD_W-1:0] rnd_6,
    input  logic [WORD_W-1:0] rnd_7,
    input  logic [WORD_W-1:0] rnd_8,
    input  logic [WORD_W-1:0] rnd_9,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic              pixel_on,
    output logic [1:0]        pixel_colour,
    output logic              scan_busy
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [NUM_ENTRIES-1:0][WORD_W-1:0] rndWords;
    logic [NUM_ENTRIES-1:0][WORD_W-1:0] snap_q;
    logic                               snapValid_q;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic [NUM_ENTRIES-1:0]            shHit_q, actHit_q, useHit;
    logic [NUM_ENTRIES-1:0][X_W-1:0]   shX_q, actX_q, useX;
    logic [NUM_ENTRIES-1:0][C_W-1:0]   shCol_q, actCol_q, useCol;

    logic [X_W-1:0] scanX;
    logic [Y_W-1:0] scanY;
    logic [C_W-1:0] scanCol;
    logic           scanHit;

    logic [9:0] nextLine;
    logic       lineEnd, frameEnd, swapNow, inArea, edgeOk;
    logic       pixelOn_q, pixelOn_d;
    logic [1:0] pixelColour_q, pixelColour_d;
    logic       unusedBits;

    assign rndWords = {rnd_9, rnd_8, rnd_7, rnd_6, rnd_5, rnd_4, rnd_3, rnd_2, rnd_1, rnd_0};
    assign nextLine = vcount + 10'd1;
    assign lineEnd  = (hcount == H_ACT);
    assign frameEnd = lineEnd && (vcount == V_LAST);
    assign swapNow  = (hcount == 10'd0);
    assign inArea   = (hcount < H_ACT) && (vcount < V_ACT);

    // Low coordinate bits that only matter in some build variants
    assign unusedBits = ^{nextLine[CELL_H_LOG2-1:0], hcount[CELL_W_LOG2-1:0]};

    rnd_cell_decode u_decode (
        .word_i   (snap_q[idx_q]),
        .x_cell_o (scanX),
        .y_cell_o (scanY),
        .colour_o (scanCol)
    );

    assign scanHit = (ROW_W'(scanY) == row_q);

    // FSM state, scan index, target row, snapshot and its valid flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            snapValid_q <= 1'b0;
            snap_q      <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            if (state_q == LOAD) begin
                snap_q      <= rndWords;
                snapValid_q <= 1'b1;
            end
        end
    end

    // Next-state logic: frame end forces a load, line end (re)starts a scan of the next line
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        scan_busy = (state_q == LOAD) || (state_q == SCAN);
        if (frameEnd) begin
            state_d = LOAD;
            idx_d   = '0;
            row_d   = '0;
        end else if (lineEnd && snapValid_q) begin
            state_d = SCAN;
            idx_d   = '0;
            row_d   = nextLine[9:CELL_H_LOG2];
        end else begin
            case (state_q)
                LOAD: begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
                SCAN: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = READY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan fills the shadow line buffer; it becomes active at the start of each line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shHit_q  <= '0;
            shX_q    <= '0;
            shCol_q  <= '0;
            actHit_q <= '0;
            actX_q   <= '0;
            actCol_q <= '0;
        end else begin
            if (state_q == SCAN) begin
                shHit_q[idx_q] <= scanHit;
                shX_q[idx_q]   <= scanX;
                shCol_q[idx_q] <= scanCol;
            end
            if (swapNow) begin
                actHit_q <= shHit_q;
                actX_q   <= shX_q;
                actCol_q <= shCol_q;
            end
        end
    end

    // The swap edge itself must already draw from the freshly scanned buffer
    assign useHit = swapNow ? shHit_q : actHit_q;
    assign useX   = swapNow ? shX_q   : actX_q;
    assign useCol = swapNow ? shCol_q : actCol_q;

    // Pixel hit test; walking from the top index down lets the lowest index win
    always_comb begin
        pixelOn_d     = 1'b0;
        pixelColour_d = '0;
        edgeOk        = 1'b1;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (useHit[i] && (hcount[9:CELL_W_LOG2] == COL_W'(useX[i]))) begin
                pixelOn_d     = 1'b1;
                pixelColour_d = useCol[i];
            end
        end
`ifdef RND_CELL_PAINTER_OUTLINE_EN
        edgeOk = (hcount[2:0] == 3'd0) || (hcount[2:0] == 3'd7) ||
                 (vcount[3:0] == 4'd0) || (vcount[3:0] == 4'd15);
`endif
        if (!(inArea && edgeOk)) begin
            pixelOn_d     = 1'b0;
            pixelColour_d = '0;
        end
    end

    // Registered pixel outputs, one clock behind the coordinates they describe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixelOn_q     <= 1'b0;
            pixelColour_q <= '0;
        end else begin
            pixelOn_q     <= pixelOn_d;
            pixelColour_q <= pixelColour_d;
        end
    end

    assign pixel_on     = pixelOn_q;
    assign pixel_colour = pixelColour_q;

endmodule

// File: doc/rnd_cell_painter.md
RND_CELL_PAINTER -- requirements
Module: rnd_cell_painter

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter V_TOTAL, 525, total lines per frame including blanking.
REQ-003 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 SHALL have port clock  input  1  pixel clock; the block uses one clock only.
REQ-005 SHALL have port reset  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have ports rnd_0..rnd_9  input  13 each  random words from the LFSR stage, stable between its half-second updates.
REQ-007 SHALL have ports hcount, vcount  input  10 each  current pixel coordinates from the sync generator.
REQ-008 SHALL have port pixel_on  output  1  current pixel lies inside a drawn cell.
REQ-009 SHALL have port pixel_colour  output  2  colour index of the winning cell; 0 when pixel_on=0.
REQ-010 SHALL have port scan_busy  output  1  high while the line scan runs.

Function
REQ-011 Each word SHALL decode as x_cell=rnd[12:7] (8-px columns), y_cell=rnd[6:2] (16-px rows), colour=rnd[1:0].
REQ-012 FSM states SHALL be IDLE, LOAD, SCAN, READY; reset state IDLE.
REQ-013 When hcount==H_ACTIVE and vcount==V_TOTAL-1, the FSM SHALL enter LOAD and copy all ten words into a frame snapshot in one cycle, then enter SCAN for line 0.
REQ-014 When hcount==H_ACTIVE on any other line, the FSM SHALL enter SCAN for line vcount+1; that cycle is ignored if no snapshot is valid.
REQ-015 SCAN SHALL test one entry per cycle, indices 0..9, setting hit[i] when zero-extended y_cell equals next_line[9:4], and SHALL take exactly 10 cycles; then READY.
REQ-016 A new scan trigger during SCAN SHALL restart the scan at index 0 with the new target line.
REQ-017 Hit mask and x_cells SHALL be double-buffered: the scan writes the shadow copy, which is swapped into the active copy when hcount==0.
REQ-018 During hcount<H_ACTIVE and vcount<V_ACTIVE, pixel_on SHALL be 1 when any active hit[i] has hcount[9:3]==zero-extended x_cell[i].
REQ-019 When several entries hit the same pixel, the lowest index SHALL supply pixel_colour.
REQ-020 pixel_on and pixel_colour SHALL be registered, one cycle after the hcount/vcount they describe.
REQ-021 Outside the active area, both outputs SHALL be 0.
REQ-022 y_cell values 30 and 31 (lines 480..511) SHALL never be drawn.
REQ-023 Changes on rnd_* mid-frame SHALL NOT affect the display until the next LOAD.
REQ-024 scan_busy SHALL be 1 exactly in LOAD and SCAN.

Reset
REQ-025 Reset SHALL clear the snapshot, both hit masks, the snapshot-valid flag and all outputs, and SHALL force IDLE.
REQ-026 After reset, the outputs SHALL stay 0 until the first LOAD plus a complete scan and swap have occurred.
REQ-027 Reset during SCAN SHALL abort it, with no partial hit mask left.

Configuration
REQ-028 With macro RND_CELL_PAINTER_OUTLINE_EN defined, pixel_on SHALL additionally require hcount[2:0] in {0,7} or vcount[3:0] in {0,15}, giving a 1-px cell outline.
REQ-029 Without RND_CELL_PAINTER_OUTLINE_EN, cells SHALL be filled 8x16 rectangles.

Structure
REQ-030 The shared package rnd_cell_painter_pkg SHALL hold NUM_ENTRIES=10, CELL_W_LOG2=3, CELL_H_LOG2=4, the word field positions and the FSM state encoding.
REQ-031 Decoding SHALL sit in the sub-module rnd_cell_decode (13-bit word in; x_cell, y_cell, colour out), instantiated once on the scan path.

Verification
REQ-032 rnd_0=13'h0A0D, others 0 (y_cell 0, x_cell 0, colour 0), one full frame: pixel_on=1 for hcount 160..167, vcount 48..63, colour 1; also hcount 0..7, vcount 0..15, colour 0.
REQ-033 rnd_2 and rnd_5 decode to the same cell with colours 3 and 2: the overlap shows colour 3.
REQ-034 rnd_0 changes mid-frame at vcount=200: the current frame is unchanged and the new cell appears from the next frame.
REQ-035 Reset asserted at vcount=100 during SCAN: outputs 0, state IDLE, and no cell is drawn until the frame after the next LOAD.
REQ-036 A word with y_cell=31: no pixel_on in any line; scan_busy pulses for 10 cycles on each line and 11 cycles at the LOAD line.
REQ-037 With RND_CELL_PAINTER_OUTLINE_EN and rnd_0=13'h0A0D: at vcount=50, pixel_on only at hcount 160 and 167; at vcount=48, pixel_on at all of hcount 160..167.
